// File: rtl/multibyte_sub_sequencer_pkg.sv
// Shared definitions for the multi-byte subtract sequencer.
//   - default byte width and byte count
//   - sequencer state enumeration
//   - helper that sizes the byte index (never narrower than 1 bit)
package multibyte_sub_sequencer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  // Width of a byte index for n slices; a single slice still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NUM_BYTES);

endpackage

// File: rtl/multibyte_sub_sequencer.sv
// Multi-byte subtract sequencer.
// Latches two wide operands and a borrow, then issues one byte pair per
// transaction (least-significant first) to an external byte subtractor over a
// sub_start/sub_done handshake, chaining the borrow and assembling the result.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             request pulse, accepted only in IDLE
//   op_a, op_b        minuend / subtrahend (DATA_WIDTH*NUM_BYTES bits)
//   borrow_in         borrow into the least-significant byte
//   result            op_a - op_b - borrow_in (modular)
//   borrow_out        borrow out of the most-significant byte
//   busy              high while bytes are being issued / awaited
//   done              one-cycle pulse, result and borrow_out valid
//   sub_a, sub_b      current byte pair presented to the byte subtractor
//   sub_borrow_in     chained borrow presented to the byte subtractor
//   sub_start         one-cycle issue strobe
//   sub_diff          byte difference returned
//   sub_borrow_out    byte borrow returned
//   sub_done          byte result valid
module multibyte_sub_sequencer
  import multibyte_sub_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_BYTES  = DEFAULT_NUM_BYTES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0] op_a,
  input  logic [DATA_WIDTH*NUM_BYTES-1:0] op_b,
  input  logic                            borrow_in,
  output logic [DATA_WIDTH*NUM_BYTES-1:0] result,
  output logic                            borrow_out,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH-1:0]           sub_a,
  output logic [DATA_WIDTH-1:0]           sub_b,
  output logic                            sub_borrow_in,
  output logic                            sub_start,
  input  logic [DATA_WIDTH-1:0]           sub_diff,
  input  logic                            sub_borrow_out,
  input  logic                            sub_done
);

  localparam int OP_W  = DATA_WIDTH * NUM_BYTES;
  localparam int IDX_W = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  seq_state_e            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [OP_W-1:0]       a_q;
  logic [OP_W-1:0]       b_q;
  logic                  borrow_q;
  logic [OP_W-1:0]       result_q;
  logic                  borrow_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] sub_a_q;
  logic [DATA_WIDTH-1:0] sub_b_q;
  logic                  sub_start_q;

  logic [IDX_W-1:0]      next_idx_d;
  logic [DATA_WIDTH-1:0] next_a_byte_d;
  logic [DATA_WIDTH-1:0] next_b_byte_d;
  logic [OP_W-1:0]       result_d;

  // Byte pair for the following index, and the result with the returned byte
  // merged in at the current index. Both are AND-OR / per-slice selects so no
  // variable part-select can reach past the operand width.
  always_comb begin
    next_idx_d    = idx_q + IDX_W'(1);
    next_a_byte_d = '0;
    next_b_byte_d = '0;
    result_d      = result_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      next_a_byte_d = next_a_byte_d |
                      ({DATA_WIDTH{next_idx_d == IDX_W'(i)}} & a_q[i*DATA_WIDTH +: DATA_WIDTH]);
      next_b_byte_d = next_b_byte_d |
                      ({DATA_WIDTH{next_idx_d == IDX_W'(i)}} & b_q[i*DATA_WIDTH +: DATA_WIDTH]);
      if (idx_q == IDX_W'(i)) begin
        result_d[i*DATA_WIDTH +: DATA_WIDTH] = sub_diff;
      end else begin
        result_d[i*DATA_WIDTH +: DATA_WIDTH] = result_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Sequencer FSM with all outputs registered. Outputs for a state are set on
  // the edge that enters it, so sub_start is high exactly in ISSUE, busy
  // covers ISSUE/WAIT, and done is high exactly in FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sub_a_q      <= '0;
      sub_b_q      <= '0;
      sub_start_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q         <= op_a;
            b_q         <= op_b;
            borrow_q    <= borrow_in;
            idx_q       <= '0;
            result_q    <= '0;
            busy_q      <= 1'b1;
            sub_start_q <= 1'b1;
            sub_a_q     <= op_a[DATA_WIDTH-1:0];
            sub_b_q     <= op_b[DATA_WIDTH-1:0];
            state_q     <= ST_ISSUE;
          end else begin
            busy_q      <= 1'b0;
            sub_start_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        // ISSUE and WAIT share the capture path; a zero-wait subtractor
        // answers in the ISSUE cycle itself and WAIT is skipped.
        ST_ISSUE, ST_WAIT: begin
          if (sub_done) begin
            result_q <= result_d;
            borrow_q <= sub_borrow_out;
            if (idx_q == LAST_IDX) begin
              borrow_out_q <= sub_borrow_out;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              sub_start_q  <= 1'b0;
              state_q      <= ST_FINISH;
            end else begin
              idx_q       <= next_idx_d;
              sub_a_q     <= next_a_byte_d;
              sub_b_q     <= next_b_byte_d;
              sub_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          end else begin
            sub_start_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end

        ST_FINISH: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          sub_start_q <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          sub_start_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign result        = result_q;
  assign borrow_out    = borrow_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sub_a         = sub_a_q;
  assign sub_b         = sub_b_q;
  assign sub_borrow_in = borrow_q;
  assign sub_start     = sub_start_q;

endmodule
